// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = '0;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between instruction memory and decode.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t      mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, redirect flush and discard.
// FETCH_BYPASS_EN: present a response straight to decode when the queue is empty.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d, count;
  fetch_entry_t    head, push_entry, dec_sel;
  logic            req_fire, rsp_keep, push, pop, bypass_hit;

  // Outstanding requests plus buffered entries never exceed DEPTH, so a
  // response always finds room in the queue.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          (({1'b0, inflight_q} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep   = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_keep && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    dec_sel = head;
    if (count == '0) dec_sel = push_entry;
  end

  assign dec_valid = rst_n && !redirect_valid && ((count != '0) || bypass_hit);
  assign dec_instr = dec_valid ? dec_sel.instr : NOP_INSTR;
  assign dec_pc    = dec_valid ? dec_sel.pc    : '0;

  assign pop  = dec_valid && dec_ready && (count != '0);
  assign push = rsp_keep && !(bypass_hit && dec_ready);

  always_comb begin
    pc_d       = req_fire ? pc_q + PC_INC : pc_q;
    rsp_pc_d   = rsp_keep ? rsp_pc_q + PC_INC : rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    // Every fetch still outstanding after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d      = align_pc(redirect_pc);
      rsp_pc_d  = align_pc(redirect_pc);
      discard_d = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency instruction memory model.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        dec_valid, dec_ready, redirect_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, dec_instr, dec_pc, redirect_pc;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0]  lat_m1;
  logic [7:0]  sr_v;
  logic [31:0] sr_a [8];
  int          acc_cnt;
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Memory answers lat_m1+1 cycles after acceptance with addr>>2 as data.
  assign imem_rsp_valid = sr_v[lat_m1];
  assign imem_rsp_data  = {2'b00, sr_a[lat_m1][31:2]};

  always @(posedge clk) begin
    if (!rst_n) begin
      sr_v    <= '0;
      acc_cnt <= 0;
      log_pc.delete();
      log_instr.delete();
    end else begin
      sr_v <= {sr_v[6:0], imem_req_valid && imem_req_ready};
      sr_a[0] <= imem_req_addr;
      for (int i = 1; i < 8; i++) sr_a[i] <= sr_a[i-1];
      if (imem_req_valid && imem_req_ready) acc_cnt <= acc_cnt + 1;
      if (dec_valid && dec_ready) begin
        log_pc.push_back(dec_pc);
        log_instr.push_back(dec_instr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] lm1, input logic rdy);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = rdy; imem_req_ready = 1'b1; lat_m1 = lm1;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and streaming with 1-cycle memory.
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b1; imem_req_ready = 1'b1; lat_m1 = 3'd0;
    step(); step(); #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    rst_n = 1'b1; #1;
    check("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    check("c0_dec_valid", {31'b0, dec_valid}, 32'd0);
    for (int c = 1; c <= 9; c++) begin
      step(); #1;
      check("stream_req_addr", imem_req_addr, 32'(4 * c));
      if (c - 2 + BYP >= 0) begin
        check("stream_dec_valid", {31'b0, dec_valid}, 32'd1);
        check("stream_dec_pc", dec_pc, 32'(4 * (c - 2 + BYP)));
        check("stream_dec_instr", dec_instr, 32'(c - 2 + BYP));
      end else begin
        check("stream_dec_idle", {31'b0, dec_valid}, 32'd0);
      end
    end

    // Decode stalled: credit limit caps outstanding work at DEPTH.
    do_reset(3'd0, 1'b0);
    for (int c = 0; c < 10; c++) step();
    #1;
    check("stall_accepts", 32'(acc_cnt), 32'd4);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall_head_pc", dec_pc, 32'h0);
    check("stall_log_empty", 32'(log_pc.size()), 32'd0);
    dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("stall_log_size_ge5", {31'b0, log_pc.size() >= 5}, 32'd1);
    if (log_pc.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("stall_drain_pc", log_pc[i], 32'(4 * i));
        check("stall_drain_instr", log_instr[i], 32'(i));
      end
    end

    // Redirect with two fetches in flight on 3-cycle memory.
    do_reset(3'd2, 1'b1);
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
    check("redir3_req_withdrawn", {31'b0, imem_req_valid}, 32'd0);
    check("redir3_dec_valid", {31'b0, dec_valid}, 32'd0);
    step();
    redirect_valid = 1'b0; #1;
    check("redir3_target_req", imem_req_addr, 32'h100);
    check("redir3_target_valid", {31'b0, imem_req_valid}, 32'd1);
    for (int c = 0; c < 10; c++) step();
    check("redir3_log_size_ge2", {31'b0, log_pc.size() >= 2}, 32'd1);
    if (log_pc.size() >= 2) begin
      check("redir3_first_pc", log_pc[0], 32'h100);
      check("redir3_first_instr", log_instr[0], 32'h40);
      check("redir3_second_pc", log_pc[1], 32'h104);
    end

    // Redirect coinciding with a returning response.
    do_reset(3'd0, 1'b1);
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    check("redir1_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
    check("redir1_dec_forced_off", {31'b0, dec_valid}, 32'd0);
    check("redir1_req_withdrawn", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0; #1;
    check("redir1_target_req", imem_req_addr, 32'h200);
    for (int k = 5; k <= 6; k++) begin
      step(); #1;
      if (k == 6 - BYP) begin
        check("redir1_n3_valid", {31'b0, dec_valid}, 32'd1);
        check("redir1_n3_pc", dec_pc, 32'h200);
      end
    end
    for (int c = 0; c < 3; c++) step();
    check("redir1_log_size", {31'b0, log_pc.size() >= 3 + BYP}, 32'd1);
    if (log_pc.size() >= 3 + BYP) begin
      check("redir1_pre_pc", log_pc[BYP], 32'(4 * BYP));
      check("redir1_tgt_pc", log_pc[1 + BYP], 32'h200);
      check("redir1_tgt_instr", log_instr[1 + BYP], 32'h80);
      check("redir1_next_pc", log_pc[2 + BYP], 32'h204);
    end

    // One-cycle reset pulse mid-stream.
    do_reset(3'd0, 1'b1);
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0; #1;
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("midrst_dec_valid", {31'b0, dec_valid}, 32'd0);
    step();
    rst_n = 1'b1; #1;
    check("postrst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("postrst_dec_pc", dec_pc, 32'd0);
    check("postrst_dec_instr", dec_instr, 32'd0);
    check("postrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("postrst_req_addr", imem_req_addr, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      step(); #1;
      if (k == 2 - BYP) begin
        check("postrst_first_valid", {31'b0, dec_valid}, 32'd1);
        check("postrst_first_pc", dec_pc, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined MIPS core: owns the PC, issues word reads to instruction memory, buffers returned instructions with their PCs in a small in-order queue, and delivers them to the decode/control stage over a valid/ready handshake. It handles branch/jump redirects by flushing buffered and in-flight fetches. When nothing is valid it drives the all-zero instruction, which decode treats as a NOP.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- DEPTH, 4, queue entries and maximum outstanding requests (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk edge)
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  32  word-aligned byte address (current PC)
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- dec_valid  out  1  dec_instr/dec_pc valid
- dec_ready  in  1  decode accepts this cycle
- dec_instr  out  32  instruction; 32'h0 when dec_valid=0
- dec_pc  out  32  PC of dec_instr; 32'h0 when dec_valid=0
- redirect_valid  in  1  branch/jump taken; highest priority
- redirect_pc  in  32  new fetch target (bits [1:0] ignored, forced 0)

## Operation
- State: pc (next request address), rsp_pc (PC of next expected response), inflight (0..DEPTH), discard (0..DEPTH), queue of {pc, instr} with count.
- Issue: imem_req_valid = (inflight + count < DEPTH) && !redirect_valid. On valid&&ready: pc += 4, inflight += 1. Address and valid stay stable until accepted, except on redirect, where the request is withdrawn (imem tolerates withdrawal).
- Response: every imem_rsp_valid decrements inflight. If discard > 0, decrement discard and drop the data. Otherwise push {rsp_pc, data} and rsp_pc += 4.
- Pop: dec_valid && dec_ready removes the head entry.
- Redirect cycle: queue flushed (count=0); pc and rsp_pc ← {redirect_pc[31:2],2'b00}; discard ← inflight, plus 1 if a request is accepted this cycle, minus 1 if a response arrives this cycle; any response in this cycle is dropped; dec_valid forced 0. First request to the target is issued the following cycle.
- Simultaneous push and pop: count unchanged, order preserved. Arithmetic wraps mod 2^32 on pc, with no overflow flag.
- Reset: pc=rsp_pc=RESET_PC; inflight=discard=count=0; imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0. Reset asserted mid-operation abandons all in-flight fetches. Imem is reset with the core, so no stale response arrives after reset.

## Timing
- Cycle 0 after rst_n rises: first request at RESET_PC.
- With 1-cycle memory and macro off: response in cycle 1, dec_valid in cycle 2 (response→decode latency 1).
- Sustained throughput is 1 instr/cycle with 1-cycle memory and dec_ready held high (DEPTH≥3).
- Redirect in cycle N: request to target in N+1; decode sees target instruction at N+3 (1-cycle memory, macro off).
- Queue full (count=DEPTH): no requests issue, and no push can occur because the credit rule prevents it.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty, a non-discarded response is presented on dec_* in the same cycle. If dec_ready is high, it is consumed without a push; otherwise it is pushed. Response→decode latency is 0.
- Undefined: all dec_* outputs come from the registered queue head only, giving a latency of 1.

## Structure
- Shared package/defines: NOP_INSTR (32'h0, matching the decode NOP rule), RESET_PC default, instruction width 32, PC increment 4.
- One sub-module: fetch_queue, a synchronous FIFO of {pc, instr} with push, pop, flush, count, and head outputs. fetch_unit holds the PC, credit logic, discard logic, and redirect logic.

## Test plan
- Reset, then 1-cycle memory returning addr>>2 as data, dec_ready=1: dec_pc sequence 0,4,8,… from cycle 2, one per cycle, dec_instr=0,1,2,….
- dec_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, then imem_req_valid=0. On release, entries 0,4,8,C are delivered in order with no loss or duplicate.
- 3-cycle memory, redirect to 0x100 while inflight=2: the two stale responses are dropped, and the next dec_pc is 0x100 followed by 0x104.
- Redirect in the same cycle as a response and a request acceptance: discard is computed correctly, and no stale instruction reaches decode.
- rst_n low for 1 cycle mid-stream: all outputs are 0 the next cycle, and fetch restarts at RESET_PC.
- FETCH_BYPASS_EN defined, empty queue, 1-cycle memory: dec_valid is asserted in cycle 1 with dec_pc=0.
